// File: rtl/cdc_led_ctrl.sv
// ---------------------------------------------------------------------------
// cdc_led_ctrl
//
// Application-side consumer of the USB CDC byte streams. It parses ASCII
// colour commands from the CDC OUT stream, answers each finished or rejected
// command with a one-byte status on the CDC IN stream, and produces three
// 8-bit PWM signals for the RGB LED driver.
//
// Command syntax: <channel letter> <hex hi> <hex lo>
//   channel letters : 'R'/'r' = red, 'G'/'g' = green, 'B'/'b' = blue
//   hex digits      : '0'-'9', 'A'-'F', 'a'-'f' (first digit = high nibble)
//   responses       : 'K' on success, '?' on any malformed byte
//   CR, LF and space are ignored between commands.
//
// Ports:
//   clk_i        application clock
//   rstn_i       asynchronous active-low reset, released synchronously
//   out_data_i   byte from CDC OUT endpoint
//   out_valid_i  out_data_i valid
//   out_ready_o  block can accept out_data_i (low while a response is pending)
//   in_data_o    status byte to CDC IN endpoint
//   in_valid_o   in_data_o valid
//   in_ready_i   CDC accepts in_data_o
//   led_o        PWM outputs: [0] red, [1] green, [2] blue
//
// Parameters:
//   PWM_DIV   clk_i cycles per PWM counter step (1..65535)
//   TIMEOUT   idle cycles tolerated inside a partial command, 0 = disabled
//   DUTY_RST  reset duty of all channels
// ---------------------------------------------------------------------------
module cdc_led_ctrl #(
    parameter int unsigned PWM_DIV  = 64,
    parameter logic [23:0] TIMEOUT  = 24'd12000000,
    parameter logic [7:0]  DUTY_RST = 8'h00
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [7:0] out_data_i,
    input  logic       out_valid_i,
    output logic       out_ready_o,
    output logic [7:0] in_data_o,
    output logic       in_valid_o,
    input  logic       in_ready_i,
    output logic [2:0] led_o
);

    localparam logic [15:0] DIV_LAST = 16'(PWM_DIV - 1);
    localparam logic [7:0]  RESP_OK  = 8'h4B;  // 'K'
    localparam logic [7:0]  RESP_ERR = 8'h3F;  // '?'

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HI   = 2'd1,
        S_LO   = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Byte classification helpers
    // -----------------------------------------------------------------------
    function automatic logic is_hex(input logic [7:0] b);
        return ((b >= 8'h30) && (b <= 8'h39)) ||
               ((b >= 8'h41) && (b <= 8'h46)) ||
               ((b >= 8'h61) && (b <= 8'h66));
    endfunction

    // Letters 'A'-'F' and 'a'-'f' share the low nibble 1..6, so adding 9
    // yields 10..15 for both cases.
    function automatic logic [3:0] hex_val(input logic [7:0] b);
        if (b <= 8'h39) begin
            return b[3:0];
        end
        return b[3:0] + 4'd9;
    endfunction

    function automatic logic is_chan(input logic [7:0] b);
        return (b == 8'h52) || (b == 8'h72) ||
               (b == 8'h47) || (b == 8'h67) ||
               (b == 8'h42) || (b == 8'h62);
    endfunction

    function automatic logic [1:0] chan_idx(input logic [7:0] b);
        logic [1:0] idx;
        idx = 2'd0;
        case (b)
            8'h47, 8'h67: idx = 2'd1;
            8'h42, 8'h62: idx = 2'd2;
            default:      idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic is_blank(input logic [7:0] b);
        return (b == 8'h0D) || (b == 8'h0A) || (b == 8'h20);
    endfunction

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [1:0]      ch_q, ch_d;
    logic [3:0]      hi_q, hi_d;
    logic            resp_valid_q, resp_valid_d;
    logic [7:0]      resp_data_q, resp_data_d;
    logic [23:0]     tmo_cnt_q, tmo_cnt_d;
    logic [15:0]     pre_cnt_q, pre_cnt_d;
    logic [7:0]      pwm_cnt_q, pwm_cnt_d;
    logic [2:0][7:0] pend_duty_q, pend_duty_d;
    logic [2:0][7:0] act_duty_q, act_duty_d;
    logic [2:0]      led_q, led_d;

    // -----------------------------------------------------------------------
    // Handshake and timeout qualifiers
    // -----------------------------------------------------------------------
    logic        take;
    logic        tick;
    logic        frame_end;
    logic        tmo_hit;
    logic [23:0] tmo_inc;

    // No byte is accepted while a response waits, which also guarantees that
    // a response is never overwritten before the host has taken it.
    assign out_ready_o = ~resp_valid_q;
    assign take        = out_valid_i & ~resp_valid_q;

    assign tmo_inc = tmo_cnt_q + 24'd1;
    // Fires on the idle cycle that would bring the counter up to TIMEOUT.
    assign tmo_hit = (TIMEOUT != 24'd0) && (state_q != S_IDLE) && !take &&
                     (tmo_inc == TIMEOUT);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (take && is_chan(out_data_i)) begin
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (take) begin
                    state_d = is_hex(out_data_i) ? S_LO : S_IDLE;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_LO: begin
                if (take || tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs (operand latches, response, pending duty)
    // -----------------------------------------------------------------------
    always_comb begin
        ch_d         = ch_q;
        hi_d         = hi_q;
        resp_data_d  = resp_data_q;
        resp_valid_d = resp_valid_q & ~in_ready_i;
        pend_duty_d  = pend_duty_q;

        if (take) begin
            case (state_q)
                S_IDLE: begin
                    if (is_chan(out_data_i)) begin
                        ch_d = chan_idx(out_data_i);
                    end else if (!is_blank(out_data_i)) begin
                        resp_valid_d = 1'b1;
                        resp_data_d  = RESP_ERR;
                    end
                end
                S_HI: begin
                    if (is_hex(out_data_i)) begin
                        hi_d = hex_val(out_data_i);
                    end else begin
                        resp_valid_d = 1'b1;
                        resp_data_d  = RESP_ERR;
                    end
                end
                S_LO: begin
                    resp_valid_d = 1'b1;
                    if (is_hex(out_data_i)) begin
                        pend_duty_d[ch_q] = {hi_q, hex_val(out_data_i)};
                        resp_data_d       = RESP_OK;
                    end else begin
                        resp_data_d = RESP_ERR;
                    end
                end
                default: begin
                    resp_valid_d = resp_valid_q;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Partial-command timeout counter
    // -----------------------------------------------------------------------
    always_comb begin
        tmo_cnt_d = tmo_inc;
        if ((TIMEOUT == 24'd0) || (state_q == S_IDLE) || take || tmo_hit) begin
            tmo_cnt_d = 24'd0;
        end
    end

    // -----------------------------------------------------------------------
    // PWM timebase
    // -----------------------------------------------------------------------
    assign tick      = (pre_cnt_q == DIV_LAST);
    assign frame_end = tick && (pwm_cnt_q == 8'hFF);

    always_comb begin
        pre_cnt_d = tick ? 16'd0 : pre_cnt_q + 16'd1;
        pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        // Register-to-register copy: a pending write landing on the same edge
        // is picked up at the following frame boundary.
        act_duty_d = frame_end ? pend_duty_q : act_duty_q;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_pwm
        assign led_d[gi] = (act_duty_q[gi] > pwm_cnt_q);
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ch_q         <= 2'd0;
            hi_q         <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 8'h00;
            tmo_cnt_q    <= 24'd0;
            pre_cnt_q    <= 16'd0;
            pwm_cnt_q    <= 8'd0;
            pend_duty_q  <= {3{DUTY_RST}};
            act_duty_q   <= {3{DUTY_RST}};
            led_q        <= 3'b000;
        end else begin
            ch_q         <= ch_d;
            hi_q         <= hi_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            tmo_cnt_q    <= tmo_cnt_d;
            pre_cnt_q    <= pre_cnt_d;
            pwm_cnt_q    <= pwm_cnt_d;
            pend_duty_q  <= pend_duty_d;
            act_duty_q   <= act_duty_d;
            led_q        <= led_d;
        end
    end

    assign in_valid_o = resp_valid_q;
    assign in_data_o  = resp_data_q;
    assign led_o      = led_q;

endmodule

// File: doc/cdc_led_ctrl.md
Name: cdc_led_ctrl

Overview:
- Application-side consumer of the USB CDC byte streams on the Fomu board.
- Parses ASCII colour commands from the CDC OUT stream.
- Returns a one-byte status on the CDC IN stream.
- Generates three 8-bit PWM signals that drive the RGBA LED driver PWM inputs, replacing the fixed LED assignment.

Parameters:
- PWM_DIV, 64: clk_i cycles per PWM counter step; legal range 1..65535. At 12 MHz the PWM frame is about 732 Hz.
- TIMEOUT, 12000000: idle cycles allowed inside a partial command before it is silently abandoned. 0 disables the timeout. 24-bit.
- DUTY_RST, 8'h00: reset duty of all three channels.

Ports:
- clk_i  input  1  application clock (12 MHz on Fomu)
- rstn_i  input  1  reset; asynchronous, active-low
- out_data_i  input  8  byte from CDC OUT endpoint
- out_valid_i  input  1  out_data_i valid
- out_ready_o  output  1  block can accept out_data_i
- in_data_o  output  8  status byte to CDC IN endpoint
- in_valid_o  output  1  in_data_o valid
- in_ready_i  input  1  CDC accepts in_data_o
- led_o  output  3  PWM outputs; [0] red, [1] green, [2] blue

Behaviour:
- Reset: all state asserts asynchronously on rstn_i low and releases synchronously to clk_i.
  - state=IDLE, in_valid_o=0, in_data_o=8'h00, led_o=3'b000.
  - pwm_cnt=0, prescale count=0, active and pending duties=DUTY_RST, timeout counter=0.
- Transfer rules:
  - A byte is taken on the rising edge where out_valid_i && out_ready_o.
  - A response completes on the edge where in_valid_o && in_ready_i.
- Flow control: out_ready_o = ~in_valid_o (combinational). No byte is consumed while a response is pending. This gives one bubble cycle after each response handshake.
- Command format: channel letter, then two hex digits.
  - Channel letters: 'R'/'r'=0, 'G'/'g'=1, 'B'/'b'=2.
  - Hex digits: '0'-'9', 'A'-'F', 'a'-'f'. The first digit is the high nibble.
- FSM, state IDLE:
  - Channel letter: latch channel, go to HI.
  - 8'h0D, 8'h0A or 8'h20: ignored, stay in IDLE, no response.
  - Any other byte: respond '?' (8'h3F), stay in IDLE.
- FSM, state HI:
  - Hex digit: latch high nibble, go to LO.
  - Any other byte: respond '?', go to IDLE.
- FSM, state LO:
  - Hex digit: pending_duty[ch] <= {hi, lo}, respond 'K' (8'h4B), go to IDLE.
  - Any other byte: respond '?', go to IDLE.
- Response timing:
  - in_data_o and in_valid_o=1 are registered on the same edge that consumes the terminating byte, so they are visible the next cycle.
  - in_data_o is held stable until the handshake; in_valid_o clears on the handshake edge.
- Timeout:
  - In HI or LO, the counter increments on every cycle with no byte consumed and clears on any consumed byte.
  - When it reaches TIMEOUT, the FSM returns to IDLE with no response and no duty change.
  - The counter is held at 0 in IDLE and when TIMEOUT=0.
- PWM prescaler:
  - The prescale counter counts 0..PWM_DIV-1 and asserts tick on PWM_DIV-1.
  - pwm_cnt increments on each tick and wraps 255->0.
- Duty update: on the tick where pwm_cnt wraps 255->0, active_duty <= pending_duty for all channels. Duty changes never cut a PWM frame short.
- PWM output:
  - led_o[i] is registered, with value (active_duty[i] > pwm_cnt).
  - Duty 0 gives constant 0; duty 255 gives high for 255 of 256 steps.
- Simultaneous events: a pending_duty write in the same cycle as the wrap tick takes effect at the next wrap, not the current one.
- Reset mid-command or mid-response: everything returns to reset values immediately. A partial command and an undelivered response are discarded.

Test Plan:
- 'R','8','0' with in_ready_i=1, PWM_DIV=1:
  - 'K' on in_data_o, one-cycle in_valid_o pulse.
  - After the next wrap, led_o[0] high for exactly 128 of each 256 cycles; led_o[2:1]=0.
- 'g','F','f' then 'B','0','0':
  - Two 'K' responses.
  - led_o[1] high 255/256 cycles; led_o[2] constantly 0.
- 'X':
  - '?' returned, FSM in IDLE.
  - Follow with 'R','z': one '?' only; duty unchanged.
- in_ready_i held 0 after 'B','4','0':
  - in_valid_o stays 1 and in_data_o stays 'K'.
  - out_ready_o=0 and next bytes are not consumed.
  - Raising in_ready_i releases them in order.
- TIMEOUT=100, send 'G','3' then idle 100 cycles, then '5':
  - No response to the partial command.
  - '5' answered with '?'; green duty unchanged.
- rstn_i low for 1 cycle while in LO with in_valid_o=1:
  - in_valid_o, led_o and duties return to reset values asynchronously.
  - Next 'R','0','1' is processed normally.
